m_2c_32b: RTL and testbench
===========================

Name: m_2c_32b

Overview:
- Sequential signed (two's-complement) 32x32 fixed-point multiplier for the fully-connected node datapath.
- Multiplies pixel value x by weight y; the product then feeds the accumulator adder.
- Radix-2 Booth, one step per clock, start/done handshake.
- Result is rescaled to Q(32-FRAC_BITS).FRAC_BITS and flags overflow.

Parameters:
- FRAC_BITS, 16, number of fractional bits in x, y and m_out; legal range 0..31.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while idle
- x  input  32  signed multiplicand, captured on the accepting edge
- y  input  32  signed multiplier, captured on the accepting edge
- busy  output  1  high while computing
- done  output  1  one-cycle pulse when m_out/ovf are updated
- m_out  output  32  signed scaled product
- ovf  output  1  scaled product did not fit in 32 signed bits

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, busy=0, done=0, m_out=0, ovf=0, step counter=0.
- States: IDLE and CALC.
- IDLE with start=1 (accepting edge):
  - latch x and y;
  - clear the 64-bit partial product;
  - counter=0;
  - go to CALC; busy=1 from the next cycle.
- CALC, each edge: one Booth step.
  - Bit pair (y[i], y[i-1]), with y[-1]=0.
  - 10: subtract x<<i; 01: add x<<i; 00/11: no change.
  - Sign-extend x to 64 bits; the add/sub goes through the adder sub-module.
- 32nd CALC edge:
  - register m_out and ovf;
  - done=1 for exactly one cycle;
  - return to IDLE; busy=0.
- Latency and throughput:
  - done asserts 32 cycles after the accepting edge.
  - start is accepted in the cycle done is high, giving one result per 33 cycles.
- start while busy: ignored, not queued. Changes on x/y during CALC have no effect.
- Arithmetic:
  - P = full 64-bit signed product.
  - S = P arithmetic-shifted right by FRAC_BITS (floor toward -inf; no rounding).
  - ovf=1 when S lies outside [-2^31, 2^31-1].
  - m_out per Optional Feature.
- m_out and ovf hold their values until the next done.
- Reset mid-CALC: immediately return to reset values; no done pulse; the partial result is discarded.

Optional Feature:
- Macro: M_2C_32B_SAT_EN.
- Defined: when ovf=1, m_out is clamped to 0x7FFFFFFF if P>0, otherwise 0x80000000.
- Undefined: m_out = S[31:0] (wrap).
- ovf behaves identically in both builds.

Decomposition:
- Package m2c_pkg holds:
  - DATA_W=32 and PROD_W=64;
  - the state enum typedef (IDLE, CALC);
  - the Booth-step encoding constants.
- Sub-module fa_32b: combinational 32-bit ripple-carry adder.
  - Ports a, b, c_in, s, c_out.
  - Instantiated twice for the low and high halves of the 64-bit add.
  - Subtract is done with ~b and c_in=1.

Test Plan (FRAC_BITS=16):
- Reset: rst_n=0 mid-CALC -> busy/done/m_out/ovf all 0 immediately; no later done.
- Basic: x=0x00018000 (1.5), y=0xFFFE0000 (-2.0) -> done exactly 32 cycles after accept; m_out=0xFFFD0000, ovf=0.
- Floor rounding:
  - x=0x00000001, y=0x00008000 -> m_out=0x00000000.
  - x=0xFFFFFFFF, y=0x00008000 -> m_out=0xFFFFFFFF.
- Overflow: x=0x7FFFFFFF, y=0x00020000 -> ovf=1; m_out=0xFFFFFFFE (wrap), or 0x7FFFFFFF with M_2C_32B_SAT_EN.
- Corner: x=y=0x80000000 -> ovf=1; m_out=0x00000000 (wrap), or 0x7FFFFFFF with SAT_EN.
- Handshake: pulse start during busy with different x/y -> ignored, result unchanged. Start in the done cycle -> accepted; next done 32 cycles later.

Source files
------------

// File: rtl/m2c_pkg.sv
// Shared widths, FSM state and Booth-step codes for the m_2c_32b multiplier.
package m2c_pkg;

  localparam int DATA_W = 32;
  localparam int PROD_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Booth pair {y[i], y[i-1]}
  localparam logic [1:0] BOOTH_NOP0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;

endpackage

// File: rtl/fa_32b.sv
// Combinational 32-bit ripple-carry adder; two of these form the 64-bit
// Booth partial-product adder.
module fa_32b
  import m2c_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
  output logic [DATA_W-1:0] s,
  output logic              c_out
);

  logic [DATA_W:0] w_c;

  assign w_c[0] = c_in;

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign c_out = w_c[DATA_W];

endmodule

// File: rtl/m_2c_32b.sv
// Sequential radix-2 Booth 32x32 signed fixed-point multiplier.
// Define M_2C_32B_SAT_EN to clamp m_out on overflow instead of wrapping.
module m_2c_32b
  import m2c_pkg::*;
#(
  parameter int FRAC_BITS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] m_out,
  output logic              ovf
);

  state_t              r_state;
  logic [PROD_W-1:0]   r_mcand;
  logic [DATA_W-1:0]   r_mplr;
  logic                r_prev;
  logic [4:0]          r_cnt;
  logic [PROD_W-1:0]   r_acc;
  logic                r_busy;
  logic                r_done;
  logic [DATA_W-1:0]   r_m_out;
  logic                r_ovf;

  logic [1:0]          w_pair;
  logic [PROD_W-1:0]   w_b;
  logic                w_cin;
  logic [PROD_W-1:0]   w_sum;
  logic                w_c_lo;
  logic                w_c_hi_unused;
  logic signed [PROD_W-1:0] w_s;
  logic                w_ovf;
  logic [DATA_W-1:0]   w_mres;

  // r_mcand holds x<<i and r_mplr holds y>>i, so bit 0 is y[i]
  assign w_pair = {r_mplr[0], r_prev};

  always_comb begin
    w_b   = '0;
    w_cin = 1'b0;
    case (w_pair)
      BOOTH_ADD: w_b = r_mcand;
      BOOTH_SUB: begin
        w_b   = ~r_mcand;
        w_cin = 1'b1;
      end
      default: ;
    endcase
  end

  fa_32b u_fa_lo (
    .a     (r_acc[DATA_W-1:0]),
    .b     (w_b[DATA_W-1:0]),
    .c_in  (w_cin),
    .s     (w_sum[DATA_W-1:0]),
    .c_out (w_c_lo)
  );

  fa_32b u_fa_hi (
    .a     (r_acc[PROD_W-1:DATA_W]),
    .b     (w_b[PROD_W-1:DATA_W]),
    .c_in  (w_c_lo),
    .s     (w_sum[PROD_W-1:DATA_W]),
    .c_out (w_c_hi_unused)
  );

  assign w_s   = $signed(w_sum) >>> FRAC_BITS;
  assign w_ovf = ~(&w_s[PROD_W-1:DATA_W-1])
               & (|w_s[PROD_W-1:DATA_W-1]);

`ifdef M_2C_32B_SAT_EN
  assign w_mres = !w_ovf     ? w_s[DATA_W-1:0] :
                  w_sum[PROD_W-1] ? 32'h8000_0000 :
                                    32'h7FFF_FFFF;
`else
  assign w_mres = w_s[DATA_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_prev  <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_m_out <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand <= {{DATA_W{x[DATA_W-1]}}, x};
            r_mplr  <= y;
            r_prev  <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_acc   <= w_sum;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          r_prev  <= r_mplr[0];
          r_cnt   <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_m_out <= w_mres;
            r_ovf   <= w_ovf;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign m_out = r_m_out;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_m_2c_32b.sv
// Directed self-checking bench for m_2c_32b at FRAC_BITS=16.
module tb_m_2c_32b;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] x;
  logic [31:0] y;
  logic        busy;
  logic        done;
  logic [31:0] m_out;
  logic        ovf;

  int n_chk;
  int n_pass;

`ifdef M_2C_32B_SAT_EN
  localparam logic [31:0] OVF_M = 32'h7FFF_FFFF;
  localparam logic [31:0] CRN_M = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] OVF_M = 32'hFFFF_FFFE;
  localparam logic [31:0] CRN_M = 32'h0000_0000;
`endif

  m_2c_32b #(.FRAC_BITS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .m_out (m_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // Counts edges from now until done is seen (bounded)
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic mul(input string tag,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] em,
                     input logic eo);
    int n;
    @(negedge clk);
    x = a;
    y = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    chk({tag, "_lat"}, 64'(n), 64'd32);
    chk({tag, "_m"}, {32'd0, m_out}, {32'd0, em});
    chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
  endtask

  initial begin
    int n;
    int n_done;
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    x      = '0;
    y      = '0;
    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_m", {32'd0, m_out}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    mul("basic", 32'h0001_8000, 32'hFFFE_0000, 32'hFFFD_0000, 1'b0);
    mul("floor_p", 32'h0000_0001, 32'h0000_8000, 32'h0000_0000, 1'b0);
    mul("floor_n", 32'hFFFF_FFFF, 32'h0000_8000, 32'hFFFF_FFFF, 1'b0);
    mul("ovf", 32'h7FFF_FFFF, 32'h0002_0000, OVF_M, 1'b1);
    mul("corner", 32'h8000_0000, 32'h8000_0000, CRN_M, 1'b1);
    mul("neg3", 32'hFFFD_0000, 32'h0002_0000, 32'hFFFA_0000, 1'b0);

    // start while busy is ignored
    @(negedge clk);
    x = 32'h0002_0000;
    y = 32'h0003_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("hs_busy", {63'd0, busy}, 64'd1);
    repeat (5) @(posedge clk);
    #1;
    x = 32'h0100_0000;
    y = 32'h0100_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    chk("hs_lat", 64'(n), 64'd26);
    chk("hs_m", {32'd0, m_out}, 64'h0006_0000);
    chk("hs_ovf", {63'd0, ovf}, 64'd0);

    // start in the done cycle is accepted
    x = 32'hFFFF_0000;
    y = 32'h0004_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    chk("b2b_done", {63'd0, done}, 64'd0);
    chk("b2b_hold", {32'd0, m_out}, 64'h0006_0000);
    wait_done(n);
    chk("b2b_lat", 64'(n), 64'd32);
    chk("b2b_m", {32'd0, m_out}, 64'hFFFC_0000);

    // reset in the middle of CALC
    @(negedge clk);
    x = 32'h0001_0000;
    y = 32'h0001_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_busy", {63'd0, busy}, 64'd0);
    chk("mid_done", {63'd0, done}, 64'd0);
    chk("mid_m", {32'd0, m_out}, 64'd0);
    chk("mid_ovf", {63'd0, ovf}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    chk("mid_nodone", 64'(n_done), 64'd0);
    chk("mid_idle", {63'd0, busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
